// File: rtl/fifo_pop_arbiter_pkg.sv
// Shared types and helpers for the FIFO pop arbiter: FSM state encoding,
// source-index width and the default packet type.
package fifo_pop_arbiter_pkg;

  localparam int DRVRS_DEF   = 4;
  localparam int PCKG_SZ_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // A single FIFO still needs a 1-bit index, so the width never drops to 0.
  function automatic int src_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int SRC_W = src_w(DRVRS_DEF);

  typedef bit [PCKG_SZ_DEF-1:0] pkt_t;

endpackage

// File: rtl/fifo_pop_arbiter_if.sv
// FIFO-bank and downstream bus signals seen by the pop arbiter.
// The master side is the arbiter; the slave side is the FIFOs plus the consumer.
interface fifo_pop_arbiter_if #(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 32,
  parameter int src_w_p = fifo_pop_arbiter_pkg::src_w(drvrs)
) ();

  logic [drvrs-1:0]         pndng;
  logic [drvrs-1:0]         pop;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic                     bus_valid;
  logic                     bus_ready;
  logic [pckg_sz-1:0]       bus_data;
  logic [src_w_p-1:0]       bus_src;

  modport master (
    input  pndng, D_pop, bus_ready,
    output pop, bus_valid, bus_data, bus_src
  );

  modport slave (
    output pndng, D_pop, bus_ready,
    input  pop, bus_valid, bus_data, bus_src
  );

endinterface

// File: rtl/fifo_pop_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant,
// wrapping modulo drvrs.
module rr_arbiter
  import fifo_pop_arbiter_pkg::*;
#(
  parameter int drvrs = 4
) (
  input  logic [drvrs-1:0]        req,
  input  logic [src_w(drvrs)-1:0] last_grant,
  output logic [src_w(drvrs)-1:0] grant,
  output logic                    any_req
);

  localparam int SW = src_w(drvrs);

  int idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    // Scan starts one past the previous winner so it gets lowest priority.
    for (int k = 1; k <= drvrs; k++) begin
      idx = (int'(last_grant) + k) % drvrs;
      if (!any_req && req[idx]) begin
        grant   = SW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Pops one packet at a time from a bank of FIFOs, round-robin, and presents it
// with its source index on a valid/ready bus.
module fifo_pop_arbiter
  import fifo_pop_arbiter_pkg::*;
#(
  parameter int drvrs   = 4,
  parameter int pckg_sz = 32,
  parameter int cnt_w   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_pop_arbiter_if.master bus,
  output logic [cnt_w-1:0] pkt_cnt
);

  localparam int SW = src_w(drvrs);

  state_e             state_q, state_d;
  logic [SW-1:0]      last_grant_q, last_grant_d;
  logic [SW-1:0]      grant_q, grant_d;
  logic [pckg_sz-1:0] bus_data_q, bus_data_d;
  logic [SW-1:0]      bus_src_q, bus_src_d;
  logic [cnt_w-1:0]   pkt_cnt_q, pkt_cnt_d;

  logic [SW-1:0]      rr_grant;
  logic               rr_any;
  logic [drvrs-1:0]   pop_v;
  logic               valid_v;
  logic [pckg_sz-1:0] head [drvrs];

  rr_arbiter #(.drvrs(drvrs)) u_rr (
    .req        (bus.pndng),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .any_req    (rr_any)
  );

  always_comb begin
    for (int i = 0; i < drvrs; i++) begin
      head[i] = bus.D_pop[i*pckg_sz +: pckg_sz];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    bus_data_d   = bus_data_q;
    bus_src_d    = bus_src_q;
    pkt_cnt_d    = pkt_cnt_q;
    pop_v        = '0;
    valid_v      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // pndng is only looked at here; later changes cannot disturb a transfer.
        if (rr_any) begin
          grant_d      = rr_grant;
          last_grant_d = rr_grant;
          state_d      = POP;
        end
      end
      POP: begin
        pop_v[grant_q] = 1'b1;
        bus_data_d     = head[grant_q];
        bus_src_d      = grant_q;
        state_d        = HOLD;
      end
      HOLD: begin
        valid_v = 1'b1;
        if (bus.bus_ready) begin
          pkt_cnt_d = pkt_cnt_q + cnt_w'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= SW'(drvrs - 1);
      grant_q      <= '0;
      bus_data_q   <= '0;
      bus_src_q    <= '0;
      pkt_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      bus_data_q   <= bus_data_d;
      bus_src_q    <= bus_src_d;
      pkt_cnt_q    <= pkt_cnt_d;
    end
  end

  // pop and bus_valid decode straight from the state so reset kills them at once.
  assign bus.pop       = pop_v;
  assign bus.bus_valid = valid_v;
  assign bus.bus_data  = bus_data_q;
  assign bus.bus_src   = bus_src_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Directed bench for fifo_pop_arbiter: reset, single source, round robin,
// backpressure, wrap-around scan, mid-transfer reset and counter wrap.
module tb_fifo_pop_arbiter;
  import fifo_pop_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst4_n;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_pop_arbiter_if #(.drvrs(4), .pckg_sz(32)) bif  ();
  fifo_pop_arbiter_if #(.drvrs(4), .pckg_sz(32)) bif4 ();

  fifo_pop_arbiter #(.drvrs(4), .pckg_sz(32), .cnt_w(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bif),
    .pkt_cnt (cnt)
  );

  fifo_pop_arbiter #(.drvrs(4), .pckg_sz(32), .cnt_w(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst4_n),
    .bus     (bif4),
    .pkt_cnt (cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bif.pndng     = '0;
    bif.bus_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_pop(input string tag);
    int n;
    n = 0;
    while (bif.pop == '0 && n < 8) begin
      tick();
      n++;
    end
    chk(tag, 64'(bif.pop != '0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    pkt_t sl;
    bif.D_pop      = '0;
    bif4.D_pop     = '0;
    bif4.pndng     = '0;
    bif4.bus_ready = 1'b0;
    rst4_n         = 1'b0;
    bif.pndng      = '0;
    bif.bus_ready  = 1'b0;

    // Reset asserted before any clock edge: outputs must already be cleared.
    rst_n = 1'b0;
    #3;
    chk("rst_pop",   bif.pop,       0);
    chk("rst_valid", bif.bus_valid, 0);
    chk("rst_cnt",   cnt,           0);
    chk("rst_data",  bif.bus_data,  0);
    chk("rst_src",   bif.bus_src,   0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single source on FIFO 2.
    for (int i = 0; i < 4; i++) bif.D_pop[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    sl = 32'hDEAD_BEEF;
    bif.D_pop[2*32 +: 32] = sl;
    bif.pndng     = 4'b0100;
    bif.bus_ready = 1'b1;
    chk("ss_idle_pop", bif.pop, 0);
    tick();
    chk("ss_pop",       bif.pop,       4'b0100);
    chk("ss_pop_valid", bif.bus_valid, 0);
    bif.pndng = '0;
    tick();
    chk("ss_hold_pop", bif.pop,       0);
    chk("ss_valid",    bif.bus_valid, 1);
    chk("ss_data",     bif.bus_data,  32'hDEAD_BEEF);
    chk("ss_src",      bif.bus_src,   2);
    chk("ss_cnt_pre",  cnt,           0);
    tick();
    chk("ss_valid_drop", bif.bus_valid, 0);
    chk("ss_cnt",        cnt,           1);
    tick();
    chk("ss_ready_idle_cnt", cnt, 1);

    // Round robin with every FIFO pending.
    do_reset();
    for (int i = 0; i < 4; i++) bif.D_pop[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    bif.pndng     = 4'b1111;
    bif.bus_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [3:0] exp_pop;
      exp_pop = 4'b0001 << (k % 4);
      wait_pop("rr_pop_seen");
      chk("rr_pop",    bif.pop, exp_pop);
      chk("rr_onehot", 64'($onehot(bif.pop)), 1);
      tick();
      chk("rr_src",  bif.bus_src,  k % 4);
      chk("rr_data", bif.bus_data, 32'hA000_0000 + 32'(k % 4));
      tick();
    end
    chk("rr_cnt", cnt, 8);

    // Backpressure: five stalled cycles, then accept.
    do_reset();
    bif.D_pop[0 +: 32] = 32'hCAFE_F00D;
    bif.pndng          = 4'b0001;
    bif.bus_ready      = 1'b0;
    tick();
    chk("bp_pop", bif.pop, 4'b0001);
    tick();
    for (int c = 0; c < 6; c++) begin
      chk("bp_valid", bif.bus_valid, 1);
      chk("bp_data",  bif.bus_data,  32'hCAFE_F00D);
      chk("bp_nopop", bif.pop,       0);
      chk("bp_cnt0",  cnt,           0);
      if (c == 5) begin
        bif.bus_ready = 1'b1;
        bif.pndng     = '0;
      end
      tick();
    end
    chk("bp_valid_drop", bif.bus_valid, 0);
    chk("bp_cnt",        cnt,           1);

    // Scan wrap: last grant 1 then only FIFO 0 pending; then last 0 with 1001.
    do_reset();
    bif.bus_ready = 1'b1;
    bif.pndng     = 4'b0010;
    tick();
    chk("skip_pop1", bif.pop, 4'b0010);
    bif.pndng = '0;
    tick();
    tick();
    bif.pndng = 4'b0001;
    tick();
    chk("skip_pop0", bif.pop, 4'b0001);
    tick();
    chk("skip_src0", bif.bus_src, 0);
    bif.pndng = 4'b1001;
    tick();
    tick();
    chk("wrap_pop3", bif.pop, 4'b1000);
    bif.pndng = '0;
    tick();
    chk("wrap_src3", bif.bus_src, 3);
    tick();
    chk("wrap_cnt3", cnt, 3);

    // Reset in HOLD, away from any edge.
    bif.pndng     = 4'b0001;
    bif.bus_ready = 1'b0;
    tick();
    tick();
    chk("mr_hold_valid", bif.bus_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_hold_valid0", bif.bus_valid, 0);
    chk("mr_hold_pop0",   bif.pop,       0);
    chk("mr_hold_cnt0",   cnt,           0);
    chk("mr_hold_data0",  bif.bus_data,  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset in POP cuts the pulse immediately.
    tick();
    chk("mr_pop", bif.pop, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_pop_cut", bif.pop, 0);
    @(posedge clk);
    #1;
    bif.pndng = 4'b1111;
    rst_n     = 1'b1;
    tick();
    chk("mr_first_pop", bif.pop, 4'b0001);
    tick();
    chk("mr_first_src", bif.bus_src, 0);

    // Counter wrap on the 4-bit instance.
    bif4.pndng     = 4'b0001;
    bif4.bus_ready = 1'b1;
    bif4.D_pop     = '0;
    rst4_n         = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      int n;
      n = 0;
      while (!bif4.bus_valid && n < 8) begin
        tick();
        n++;
      end
      chk("wrap_valid_seen", bif4.bus_valid, 1);
      tick();
      if (k >= 15) chk("wrap_cnt", cnt4, k % 16);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_pop_arbiter.md
Name: fifo_pop_arbiter

Overview:
- Consumer ("pop side") for a bank of per-device FIFOs, each exposing pndng / pop / D_pop.
- Watches every FIFO's pndng and picks one FIFO round-robin.
- Issues a single-cycle pop to that FIFO and captures the popped packet.
- Presents the packet, tagged with its source index, on a shared valid/ready bus toward the bus model or scoreboard.

Parameters:
- drvrs, 4, number of attached FIFOs/devices (>=2).
- pckg_sz, 32, packet width in bits.
- cnt_w, 16, width of the delivered-packet counter.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pndng  input  drvrs  bit i high = FIFO i holds at least one packet.
- pop  output  drvrs  one-hot pop pulse to FIFO i.
- D_pop  input  drvrs*pckg_sz  packed; slice i = FIFO i head data.
- bus_valid  output  1  packet on bus_data is valid.
- bus_ready  input  1  downstream accepts when high together with bus_valid.
- bus_data  output  pckg_sz  delivered packet.
- bus_src  output  max(1,$clog2(drvrs))  index of the source FIFO.
- pkt_cnt  output  cnt_w  count of packets accepted downstream.

Behaviour:
- Reset: asserting rst_n=0 forces all of the following immediately, regardless of clk:
  - state=IDLE
  - pop=0, bus_valid=0, bus_data=0, bus_src=0, pkt_cnt=0
  - last_grant=drvrs-1, so FIFO 0 has first priority.
- FSM states: IDLE, POP, HOLD.
- IDLE:
  - pop=0, bus_valid=0.
  - If any pndng bit is high, grant = first i with pndng[i]=1, scanning last_grant+1, last_grant+2, ... modulo drvrs.
  - On that grant, latch grant, set last_grant=grant, go to POP.
  - If no pndng bit is high, stay in IDLE.
- POP:
  - pop[grant]=1 for exactly one cycle; all other pop bits are 0.
  - At the closing clock edge, D_pop slice grant goes into bus_data and grant into bus_src.
  - Next state is HOLD.
- HOLD:
  - bus_valid=1; bus_data and bus_src are stable while bus_ready=0.
  - On an edge with bus_ready=1: pkt_cnt+1, bus_valid drops next cycle, go to IDLE.
- Latency: pndng rise in IDLE -> pop high next cycle -> bus_valid high the cycle after.
  - Peak throughput is one packet per 3 cycles while bus_ready is held high.
- pndng is sampled only in IDLE.
  - A pndng change during POP or HOLD has no effect on the current transaction.
  - The pop pulse is issued even if pndng[grant] fell during POP; the FIFO must tolerate pop while empty.
- pop is never asserted in IDLE or HOLD.
  - At most one pop bit is high in any cycle.
  - No second pop is issued before the previous packet is accepted.
- Fairness: with all pndng held high, grants cycle 0,1,...,drvrs-1,0,...
  - No FIFO waits more than drvrs grants.
- pkt_cnt wraps from 2^cnt_w-1 to 0 with no flag.
- bus_ready high outside HOLD is ignored.
- Reset mid-transaction:
  - In POP, the pop pulse is cut off immediately; a partially popped packet is lost by design.
  - In HOLD, bus_valid drops immediately and the packet is discarded.
- Round-robin wrap: when last_grant=drvrs-1, the scan starts at 0.

Decomposition:
- Shared package holds:
  - state enum (IDLE, POP, HOLD)
  - SRC_W = max(1,$clog2(drvrs)) function/localparam
  - packet typedef bit[pckg_sz-1:0]
- One sub-module, rr_arbiter:
  - inputs: req[drvrs], last_grant
  - outputs: grant index, any_req
  - purely combinational priority rotation.
  - The top level holds the FSM, data/source registers and pkt_cnt.

Test Plan:
- Reset check: drive rst_n=0 mid-HOLD with bus_ready=0 -> bus_valid, pop and pkt_cnt go to 0 asynchronously; after release, the first grant goes to FIFO 0.
- Single source: pndng=4'b0100, D_pop slice2=32'hDEADBEEF, bus_ready=1 ->
  - pop=4'b0100 for exactly one cycle
  - next cycle bus_valid=1, bus_data=32'hDEADBEEF, bus_src=2
  - pkt_cnt=1.
- Round robin: pndng=4'b1111 held high, bus_ready=1, 8 packets -> bus_src sequence 0,1,2,3,0,1,2,3; pkt_cnt=8; each pop is one-hot.
- Backpressure: pndng=4'b0001, bus_ready=0 for 5 cycles then 1 ->
  - bus_valid held 6 cycles with bus_data unchanged
  - no second pop issued
  - pkt_cnt increments once.
- Skip idle sources: last_grant=1 with pndng=4'b0001 -> scan wraps and grants FIFO 0 (bus_src=0).
- Counter wrap with cnt_w=4: 17 accepted packets -> pkt_cnt reads 15 then 0 then 1.
